// File: rtl/keyboard_line_controller.sv
// Turns PS/2 set-2 key events into an editable ASCII command line and hands it to the CPU
// over a valid/ready handshake. Optional tail-word view enabled by defining KBD_TAIL_WORD_EN.
module keyboard_line_controller #(
  parameter int unsigned LINE_LEN = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LEN_W    = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        data_PS2key,
  input  logic              ctrl_PS2pressed,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_char,
  output logic [LEN_W-1:0]  line_len,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [LEN_W-1:0]  cmd_len,
  output logic              drop_pulse,
  output logic [31:0]       tail_word
);

  typedef enum logic [1:0] {
    S_EDIT   = 2'd0,
    S_SUBMIT = 2'd1,
    S_CLEAR  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               pressed_q, pressed_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [LEN_W-1:0]   cmd_len_q, cmd_len_d;
  logic               drop_q, drop_d;

  logic [7:0]         line_buf [LINE_LEN];
  logic [7:0]         key_ascii_c;
  logic               key_print_c;
  logic               key_bs_c;
  logic               key_enter_c;
  logic               press_rise_c;
  logic               full_c;
  logic               wr_en_c;

  assign press_rise_c = ctrl_PS2pressed & ~pressed_q;
  assign full_c       = (len_q == LEN_W'(LINE_LEN));

  // Set-2 make code to ASCII; zero means "not printable"
  always_comb begin
    key_ascii_c = 8'h00;
    case (data_PS2key)
      8'h1C: key_ascii_c = 8'h41;  8'h32: key_ascii_c = 8'h42;
      8'h21: key_ascii_c = 8'h43;  8'h23: key_ascii_c = 8'h44;
      8'h24: key_ascii_c = 8'h45;  8'h2B: key_ascii_c = 8'h46;
      8'h34: key_ascii_c = 8'h47;  8'h33: key_ascii_c = 8'h48;
      8'h43: key_ascii_c = 8'h49;  8'h3B: key_ascii_c = 8'h4A;
      8'h42: key_ascii_c = 8'h4B;  8'h4B: key_ascii_c = 8'h4C;
      8'h3A: key_ascii_c = 8'h4D;  8'h31: key_ascii_c = 8'h4E;
      8'h44: key_ascii_c = 8'h4F;  8'h4D: key_ascii_c = 8'h50;
      8'h15: key_ascii_c = 8'h51;  8'h2D: key_ascii_c = 8'h52;
      8'h1B: key_ascii_c = 8'h53;  8'h2C: key_ascii_c = 8'h54;
      8'h3C: key_ascii_c = 8'h55;  8'h2A: key_ascii_c = 8'h56;
      8'h1D: key_ascii_c = 8'h57;  8'h22: key_ascii_c = 8'h58;
      8'h35: key_ascii_c = 8'h59;  8'h1A: key_ascii_c = 8'h5A;
      8'h45: key_ascii_c = 8'h30;  8'h16: key_ascii_c = 8'h31;
      8'h1E: key_ascii_c = 8'h32;  8'h26: key_ascii_c = 8'h33;
      8'h25: key_ascii_c = 8'h34;  8'h2E: key_ascii_c = 8'h35;
      8'h36: key_ascii_c = 8'h36;  8'h3D: key_ascii_c = 8'h37;
      8'h3E: key_ascii_c = 8'h38;  8'h46: key_ascii_c = 8'h39;
      8'h29: key_ascii_c = 8'h20;  8'h4E: key_ascii_c = 8'h2D;
      default: key_ascii_c = 8'h00;
    endcase
  end

  assign key_print_c = (key_ascii_c != 8'h00);
  assign key_bs_c    = (data_PS2key == 8'h66);
  assign key_enter_c = (data_PS2key == 8'h5A);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pressed_d   = ctrl_PS2pressed;
    len_d       = len_q;
    cmd_valid_d = cmd_valid_q;
    cmd_len_d   = cmd_len_q;
    drop_d      = 1'b0;
    wr_en_c     = 1'b0;
    case (state_q)
      S_EDIT: begin
        if (press_rise_c) begin
          if (key_print_c) begin
            if (!full_c) begin
              wr_en_c = ~reset;
              len_d   = len_q + LEN_W'(1);
            end else begin
              drop_d = 1'b1;
            end
          end else if (key_bs_c && (len_q != '0)) begin
            len_d = len_q - LEN_W'(1);
          end else if (key_enter_c && (len_q != '0)) begin
            state_d     = S_SUBMIT;
            cmd_valid_d = 1'b1;
            cmd_len_d   = len_q;
          end
        end
      end
      S_SUBMIT: begin
        drop_d = press_rise_c;
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        drop_d      = press_rise_c;
        cmd_valid_d = 1'b0;
        len_d       = '0;
        state_d     = S_EDIT;
      end
      default: state_d = S_EDIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_EDIT;
      pressed_q   <= 1'b0;
      len_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_len_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pressed_q   <= pressed_d;
      len_q       <= len_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_len_q   <= cmd_len_d;
      drop_q      <= drop_d;
    end
  end

  // Line storage is deliberately left uninitialised; len_q bounds every read
  always_ff @(posedge clock) begin
    if (wr_en_c) line_buf[len_q[ADDR_W-1:0]] <= key_ascii_c;
  end

  assign rd_char    = (LEN_W'(rd_addr) < len_q) ? line_buf[rd_addr] : 8'h00;
  assign line_len   = len_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_len    = cmd_len_q;
  assign drop_pulse = drop_q;

`ifdef KBD_TAIL_WORD_EN
  // Newest character in the low byte; positions before the line start read zero
  always_comb begin
    tail_word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (len_q > LEN_W'(i))
        tail_word[8*i +: 8] = line_buf[ADDR_W'(len_q - LEN_W'(i + 1))];
    end
  end
`else
  assign tail_word = 32'h0;
`endif

endmodule

// File: tb/tb_keyboard_line_controller.sv
// Directed self-checking bench for keyboard_line_controller.
module tb_keyboard_line_controller;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LEN_W  = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        data_PS2key;
  logic              ctrl_PS2pressed;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_char;
  logic [LEN_W-1:0]  line_len;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              drop_pulse;
  logic [31:0]       tail_word;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;
  int drop_base;

  keyboard_line_controller #(.LINE_LEN(32), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .data_PS2key     (data_PS2key),
    .ctrl_PS2pressed (ctrl_PS2pressed),
    .rd_addr         (rd_addr),
    .rd_char         (rd_char),
    .line_len        (line_len),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_len         (cmd_len),
    .drop_pulse      (drop_pulse),
    .tail_word       (tail_word)
  );

  always #5 clock = ~clock;

  // Counts every cycle drop_pulse is high, so a 1-cycle pulse adds exactly one
  always @(posedge clock) if (drop_pulse === 1'b1) drop_cnt <= drop_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ctrl_PS2pressed = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic press_key(input logic [7:0] code, input int hold);
    data_PS2key = code;
    ctrl_PS2pressed = 1'b1;
    tick(hold);
    ctrl_PS2pressed = 1'b0;
    tick(3);
  endtask

  function automatic logic [31:0] tail_exp(input logic [31:0] v);
`ifdef KBD_TAIL_WORD_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    data_PS2key = 8'h00;
    ctrl_PS2pressed = 1'b0;
    rd_addr = '0;
    cmd_ready = 1'b0;

    // 1: reset state
    do_reset();
    check_eq("rst_len", 32'(line_len), 32'd0);
    check_eq("rst_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_drop", 32'(drop_pulse), 32'd0);
    check_eq("rst_cmdlen", 32'(cmd_len), 32'd0);
    check_eq("rst_tail", tail_word, 32'h0);

    // 2: type A N D 6, one of them held long
    press_key(8'h1C, 5);
    press_key(8'h31, 20);
    press_key(8'h23, 5);
    press_key(8'h36, 6);
    check_eq("type_len", 32'(line_len), 32'd4);
    rd_addr = 5'd0; #1 check_eq("rd0", 32'(rd_char), 32'h41);
    rd_addr = 5'd1; #1 check_eq("rd1", 32'(rd_char), 32'h4E);
    rd_addr = 5'd2; #1 check_eq("rd2", 32'(rd_char), 32'h44);
    rd_addr = 5'd3; #1 check_eq("rd3", 32'(rd_char), 32'h36);
    rd_addr = 5'd4; #1 check_eq("rd_past_len", 32'(rd_char), 32'h00);
    check_eq("type_tail", tail_word, tail_exp(32'h414E4436));
    drop_base = drop_cnt;
    press_key(8'hF0, 5);
    press_key(8'hE0, 5);
    check_eq("unmapped_len", 32'(line_len), 32'd4);
    check_eq("unmapped_nodrop", 32'(drop_cnt - drop_base), 32'd0);

    // 3: backspace behaviour
    do_reset();
    drop_base = drop_cnt;
    press_key(8'h66, 5);
    check_eq("bs_empty_len", 32'(line_len), 32'd0);
    check_eq("bs_empty_nodrop", 32'(drop_cnt - drop_base), 32'd0);
    press_key(8'h1C, 5);
    press_key(8'h31, 5);
    press_key(8'h66, 5);
    check_eq("bs_len", 32'(line_len), 32'd1);
    check_eq("bs_tail", tail_word, tail_exp(32'h00000041));
    rd_addr = 5'd1; #1 check_eq("bs_rd1", 32'(rd_char), 32'h00);

    // 4: overflow on the 33rd character
    do_reset();
    drop_base = drop_cnt;
    for (int i = 0; i < 32; i++) press_key((i == 31) ? 8'h45 : 8'h1C, 2);
    check_eq("full_len", 32'(line_len), 32'd32);
    check_eq("full_nodrop", 32'(drop_cnt - drop_base), 32'd0);
    press_key(8'h32, 4);
    check_eq("ovf_len", 32'(line_len), 32'd32);
    check_eq("ovf_drop_once", 32'(drop_cnt - drop_base), 32'd1);
    rd_addr = 5'd31; #1 check_eq("full_rd31", 32'(rd_char), 32'h30);
    check_eq("full_tail", tail_word, tail_exp(32'h41414130));

    // 5: submit "ABC" with a stalled CPU
    do_reset();
    press_key(8'h1C, 5);
    press_key(8'h32, 5);
    press_key(8'h21, 5);
    press_key(8'h5A, 4);
    check_eq("sub_valid", 32'(cmd_valid), 32'd1);
    check_eq("sub_cmdlen", 32'(cmd_len), 32'd3);
    drop_base = drop_cnt;
    press_key(8'h1C, 4);
    check_eq("sub_drop", 32'(drop_cnt - drop_base), 32'd1);
    check_eq("sub_len_held", 32'(line_len), 32'd3);
    check_eq("sub_valid_held", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_eq("acc_valid_low", 32'(cmd_valid), 32'd0);
    check_eq("acc_len_still", 32'(line_len), 32'd3);
    tick(1);
    check_eq("clr_len", 32'(line_len), 32'd0);
    press_key(8'h24, 5);
    check_eq("edit_again_len", 32'(line_len), 32'd1);
    rd_addr = 5'd0; #1 check_eq("edit_again_rd0", 32'(rd_char), 32'h45);

    // 6: empty enter, then reset during submit
    do_reset();
    cmd_ready = 1'b1;
    press_key(8'h5A, 5);
    check_eq("enter_empty", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
    press_key(8'h1C, 5);
    press_key(8'h5A, 5);
    check_eq("sub1_valid", 32'(cmd_valid), 32'd1);
    check_eq("sub1_cmdlen", 32'(cmd_len), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("rst_sub_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_sub_len", 32'(line_len), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
